// File: rtl/io_input_debounce.sv
// io_input_debounce: synchronized, tick-sampled debouncer for 16 switches and 5 buttons behind an IO read port.
// Define IO_BTN_EVENT_EN to add sticky button-press events, read and cleared at address 11.
module io_input_debounce #(
    parameter int TICK_DIV = 100000,
    parameter int STABLE_N = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw_raw,
    input  logic [4:0]  btn_raw,
    input  logic [31:0] io_address,
    input  logic        io_read_en,
    output logic [31:0] io_read_value
);
    localparam int NB = 21;
    localparam int CW = $clog2(TICK_DIV);

    logic [NB-1:0] s1, s2, db, db_nxt;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [31:0]   evt_word;
    logic [1:0]    a;
    logic          unused;

    assign tick   = cnt == CW'(TICK_DIV - 1);
    assign a      = io_address[1:0];
    assign unused = ^io_address[31:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= '0;
            s2  <= '0;
            cnt <= '0;
            db  <= '0;
        end else begin
            s1  <= {btn_raw, sw_raw};
            s2  <= s1;
            cnt <= tick ? '0 : cnt + CW'(1);
            db  <= db_nxt;
        end
    end

    // The acceptance test includes the sample being shifted in on this tick.
    for (genvar b = 0; b < NB; b++) begin : g_bit
        logic [STABLE_N-1:0] h, h_nxt;
        assign h_nxt     = {h[STABLE_N-2:0], s2[b]};
        assign db_nxt[b] = (tick && (&h_nxt || ~|h_nxt)) ? s2[b] : db[b];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                h <= '0;
            else if (tick)
                h <= h_nxt;
        end
    end

`ifdef IO_BTN_EVENT_EN
    logic [4:0] btn_evt;
    logic       evt_clr;
    assign evt_clr  = io_read_en && a == 2'b11;
    assign evt_word = {27'h0, btn_evt};
    // A rise landing on a clearing read survives: set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            btn_evt <= '0;
        else
            btn_evt <= (evt_clr ? 5'h0 : btn_evt) | (db_nxt[20:16] & ~db[20:16]);
    end
`else
    assign evt_word = 32'h0;
`endif

    assign io_read_value = !(io_read_en && rst_n) ? 32'h0 :
                           a == 2'b01 ? {16'h0, db[15:0]} :
                           a == 2'b10 ? {27'h0, db[20:16]} :
                           a == 2'b11 ? evt_word : 32'h0;
endmodule

// File: tb/tb_io_input_debounce.sv
// tb_io_input_debounce: directed checks of io_input_debounce with TICK_DIV=4, STABLE_N=3.
// Event checks follow IO_BTN_EVENT_EN; without it address 11 must read zero.
module tb_io_input_debounce;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [15:0] sw_raw = '0;
    logic [4:0]  btn_raw = '0;
    logic [31:0] io_address = '0;
    logic        io_read_en = 0;
    logic [31:0] io_read_value;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    io_input_debounce #(.TICK_DIV(4), .STABLE_N(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .btn_raw(btn_raw),
        .io_address(io_address),
        .io_read_en(io_read_en),
        .io_read_value(io_read_value)
    );

    always #5 clk = ~clk;

    // Edges since reset release; prescaler ticks land on multiples of 4.
    always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        io_address = {30'h0, a};
        io_read_en = 1;
        #1;
        v = io_read_value;
        io_read_en = 0;
        #1;
    endtask

    task automatic rd_clr(output logic [31:0] v);
        io_address = 32'h3;
        io_read_en = 1;
        #1;
        v = io_read_value;
        @(posedge clk);
        #1;
        io_read_en = 0;
    endtask

    task automatic wait_val(input logic [1:0] a, input logic [31:0] exp, input int max, output int n);
        logic [31:0] v;
        n = 0;
        peek(a, v);
        while (v !== exp && n < max) begin
            step();
            n++;
            peek(a, v);
        end
    endtask

    function automatic int ntick(input int x);
        return ((x + 3) / 4) * 4;
    endfunction

    initial begin : main
        logic [31:0] v, acc;
        int n, e0, u;
        sw_raw  = 16'hFFFF;
        btn_raw = 5'h1F;
        step(2);
        peek(2'b01, v); chk("rst_sw", v, 32'h0);
        peek(2'b10, v); chk("rst_btn", v, 32'h0);
        step();
        peek(2'b11, v); chk("rst_evt", v, 32'h0);
        sw_raw  = '0;
        btn_raw = '0;
        step();
        rst_n = 1;
        step(3);
        peek(2'b01, v); chk("idle_sw", v, 32'h0);
        peek(2'b10, v); chk("idle_btn", v, 32'h0);
        peek(2'b11, v); chk("idle_evt", v, 32'h0);

        e0 = cyc;
        sw_raw = 16'hA5C3;
        wait_val(2'b01, 32'h0000A5C3, 30, n);
        chk("sw_latency", n, ntick(e0 + 3) + 8 - e0);
        step(8);
        peek(2'b01, v); chk("sw_hold", v, 32'h0000A5C3);
        peek(2'b00, v); chk("addr00", v, 32'h0);
        peek(2'b10, v); chk("btn_idle", v, 32'h0);

        btn_raw[2] = 1;
        step(5);
        btn_raw[2] = 0;
        acc = '0;
        repeat (20) begin
            step();
            peek(2'b10, v); acc |= v;
            peek(2'b11, v); acc |= v;
        end
        chk("glitch", acc, 32'h0);

        btn_raw[0] = 1;
        step(20);
        peek(2'b10, v); chk("btn0_db", v, 32'h1);
`ifdef IO_BTN_EVENT_EN
        rd_clr(v); chk("evt_read", v, 32'h1);
        rd_clr(v); chk("evt_cleared", v, 32'h0);
`else
        peek(2'b11, v); chk("evt_off", v, 32'h0);
`endif
        btn_raw[0] = 0;
        step(20);
        peek(2'b10, v); chk("btn0_release", v, 32'h0);
        peek(2'b11, v); chk("fall_no_evt", v, 32'h0);

        e0 = cyc;
        btn_raw[4] = 1;
        u = ntick(e0 + 3) + 8;
        while (cyc < u - 1) step();
        peek(2'b10, v); chk("b4_pre", v, 32'h0);
`ifdef IO_BTN_EVENT_EN
        rd_clr(v); chk("b4_clr_read", v, 32'h0);
        peek(2'b11, v); chk("b4_set_wins", v, 32'h10);
        peek(2'b10, v); chk("b4_db", v, 32'h10);
        rd_clr(v); chk("b4_next_read", v, 32'h10);
        peek(2'b11, v); chk("b4_after_clr", v, 32'h0);
`else
        step();
        peek(2'b10, v); chk("b4_db", v, 32'h10);
        peek(2'b11, v); chk("evt_off_b4", v, 32'h0);
`endif

        btn_raw = '0;
        step(20);
        sw_raw = 16'hFFFF;
        step(6);
        rst_n = 0;
        peek(2'b01, v); chk("mid_rst_sw", v, 32'h0);
        peek(2'b10, v); chk("mid_rst_btn", v, 32'h0);
        peek(2'b11, v); chk("mid_rst_evt", v, 32'h0);
        step(2);
        rst_n = 1;
        peek(2'b01, v); chk("post_rst_sw", v, 32'h0);
        wait_val(2'b01, 32'h0000FFFF, 30, n);
        chk("rst_latency", n, 12);
        peek(2'b11, v); chk("post_rst_evt", v, 32'h0);
        peek(2'b10, v); chk("post_rst_btn", v, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
